// File: rtl/if_id_stage_pkg.sv
// if_id_stage_pkg: shared LC-3b types (package lc3b_types) for the IF/ID stage and its field decoder.
//   lc3b_opcode        - 4-bit opcode enum
//   lc3b_* field types - raw (unextended) instruction field widths
//   lc3b_if_id_fields  - bundle of every decode output presented to control ROM / regfile
package lc3b_types;
    typedef enum logic [3:0] {
        op_br   = 4'd0,
        op_add  = 4'd1,
        op_ldb  = 4'd2,
        op_stb  = 4'd3,
        op_jsr  = 4'd4,
        op_and  = 4'd5,
        op_ldr  = 4'd6,
        op_str  = 4'd7,
        op_rti  = 4'd8,
        op_not  = 4'd9,
        op_ldi  = 4'd10,
        op_sti  = 4'd11,
        op_jmp  = 4'd12,
        op_shf  = 4'd13,
        op_lea  = 4'd14,
        op_trap = 4'd15
    } lc3b_opcode;

    typedef logic [2:0]  lc3b_reg;
    typedef logic [5:0]  lc3b_offset6;
    typedef logic [4:0]  lc3b_imm5;
    typedef logic [3:0]  lc3b_imm4;
    typedef logic [7:0]  lc3b_trapvect8;
    typedef logic [8:0]  lc3b_offset9;
    typedef logic [10:0] lc3b_offset11;

    typedef struct packed {
        lc3b_opcode    opcode;
        lc3b_reg       dest;
        lc3b_reg       sr1;
        lc3b_reg       sr2;
        lc3b_offset6   offset6;
        lc3b_imm5      imm5;
        lc3b_imm4      imm4;
        lc3b_trapvect8 trapvect8;
        lc3b_offset9   offset9;
        lc3b_offset11  offset11;
        logic          ir11;
        logic          ir5;
        logic          ir4;
    } lc3b_if_id_fields;
endpackage

// File: rtl/if_id_stage_field_decode.sv
// lc3b_field_decode: combinational slicing of a 16-bit LC-3b instruction into decode fields.
//   inst     in  16 : instruction
//   link_reg in  3  : register forced as dest for JSR/TRAP
//   fields   out    : lc3b_if_id_fields bundle (no sign extension)
module lc3b_field_decode
    import lc3b_types::*;
(
    input  logic [15:0]      inst,
    input  lc3b_reg          link_reg,
    output lc3b_if_id_fields fields
);
    lc3b_opcode op;

    assign op = lc3b_opcode'(inst[15:12]);

    always_comb begin
        fields           = '0;
        fields.opcode    = op;
        fields.dest      = (op == op_jsr || op == op_trap) ? link_reg : inst[11:9];
        fields.sr1       = inst[8:6];
        fields.sr2       = inst[2:0];
        fields.offset6   = inst[5:0];
        fields.imm5      = inst[4:0];
        fields.imm4      = inst[3:0];
        fields.trapvect8 = inst[7:0];
        fields.offset9   = inst[8:0];
        fields.offset11  = inst[10:0];
        fields.ir11      = inst[11];
        fields.ir5       = inst[5];
        fields.ir4       = inst[4];
    end
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: elastic valid/ready IF/ID pipeline stage with flush and pre-sliced decode fields.
//   clk, reset (sync, active-low)
//   in_valid/in_ready/in_inst/in_pc     : fetch side
//   flush                               : drop every held and incoming entry
//   out_valid/out_ready/out_inst/out_pc : decode side (data reads 0 when not valid)
//   count                               : occupancy
//   opcode..ir4                         : fields sliced from the head instruction
// Build option: IF_ID_SKID_EN adds a skid register and a registered in_ready.
module if_id_stage
    import lc3b_types::*;
#(
    parameter int         INST_W   = 16,
    parameter int         PC_W     = 16,
    parameter logic [2:0] LINK_REG = 3'd7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic [1:0]        count,
    output logic [3:0]        opcode,
    output logic [2:0]        dest,
    output logic [2:0]        sr1,
    output logic [2:0]        sr2,
    output logic [5:0]        offset6,
    output logic [4:0]        imm5,
    output logic [3:0]        imm4,
    output logic [7:0]        trapvect8,
    output logic [8:0]        offset9,
    output logic [10:0]       offset11,
    output logic              ir11,
    output logic              ir5,
    output logic              ir4
);
    logic              fire, acc;
    logic              head_valid, head_valid_n;
    logic [INST_W-1:0] head_inst, head_inst_n;
    logic [PC_W-1:0]   head_pc, head_pc_n;
    lc3b_if_id_fields  f;

    assign fire = head_valid & out_ready;
    assign acc  = in_valid & in_ready;

`ifdef IF_ID_SKID_EN
    logic              skid_valid, skid_valid_n, rdy_q;
    logic [INST_W-1:0] skid_inst, skid_inst_n;
    logic [PC_W-1:0]   skid_pc, skid_pc_n;

    // in_ready is 0 while the skid is full, so an accept never meets a full skid.
    always_comb begin
        head_valid_n = head_valid;
        head_inst_n  = head_inst;
        head_pc_n    = head_pc;
        skid_valid_n = skid_valid;
        skid_inst_n  = skid_inst;
        skid_pc_n    = skid_pc;
        if (skid_valid) begin
            if (fire) begin
                head_valid_n = 1'b1;
                head_inst_n  = skid_inst;
                head_pc_n    = skid_pc;
                skid_valid_n = 1'b0;
                skid_inst_n  = '0;
                skid_pc_n    = '0;
            end
        end else if (~head_valid | fire) begin
            head_valid_n = acc;
            head_inst_n  = acc ? in_inst : '0;
            head_pc_n    = acc ? in_pc : '0;
        end else if (acc) begin
            skid_valid_n = 1'b1;
            skid_inst_n  = in_inst;
            skid_pc_n    = in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            skid_valid <= 1'b0;
            skid_inst  <= '0;
            skid_pc    <= '0;
            rdy_q      <= 1'b0;
        end else if (flush) begin
            skid_valid <= 1'b0;
            skid_inst  <= '0;
            skid_pc    <= '0;
            rdy_q      <= 1'b1;
        end else begin
            skid_valid <= skid_valid_n;
            skid_inst  <= skid_inst_n;
            skid_pc    <= skid_pc_n;
            rdy_q      <= ~skid_valid_n;
        end
    end

    assign in_ready = rdy_q & reset;
    assign count    = {1'b0, head_valid} + {1'b0, skid_valid};
`else
    always_comb begin
        head_valid_n = head_valid;
        head_inst_n  = head_inst;
        head_pc_n    = head_pc;
        if (~head_valid | fire) begin
            head_valid_n = acc;
            head_inst_n  = acc ? in_inst : '0;
            head_pc_n    = acc ? in_pc : '0;
        end
    end

    assign in_ready = reset & (~head_valid | out_ready);
    assign count    = {1'b0, head_valid};
`endif

    // Empty head holds zero data so out_inst/out_pc read 0 (a NOP) when invalid.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            head_valid <= 1'b0;
            head_inst  <= '0;
            head_pc    <= '0;
        end else begin
            head_valid <= head_valid_n;
            head_inst  <= head_inst_n;
            head_pc    <= head_pc_n;
        end
    end

    assign out_valid = head_valid;
    assign out_inst  = head_inst;
    assign out_pc    = head_pc;

    lc3b_field_decode u_dec (
        .inst     (head_inst[15:0]),
        .link_reg (LINK_REG),
        .fields   (f)
    );

    assign opcode    = f.opcode;
    assign dest      = f.dest;
    assign sr1       = f.sr1;
    assign sr2       = f.sr2;
    assign offset6   = f.offset6;
    assign imm5      = f.imm5;
    assign imm4      = f.imm4;
    assign trapvect8 = f.trapvect8;
    assign offset9   = f.offset9;
    assign offset11  = f.offset11;
    assign ir11      = f.ir11;
    assign ir5       = f.ir5;
    assign ir4       = f.ir4;
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed self-checking bench for if_id_stage (either IF_ID_SKID_EN build).
module tb_if_id_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_inst = '0;
    logic [15:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_inst;
    logic [15:0] out_pc;
    logic [1:0]  count;
    logic [3:0]  opcode;
    logic [2:0]  dest, sr1, sr2;
    logic [5:0]  offset6;
    logic [4:0]  imm5;
    logic [3:0]  imm4;
    logic [7:0]  trapvect8;
    logic [8:0]  offset9;
    logic [10:0] offset11;
    logic        ir11, ir5, ir4;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    if_id_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .count(count),
        .opcode(opcode), .dest(dest), .sr1(sr1), .sr2(sr2), .offset6(offset6),
        .imm5(imm5), .imm4(imm4), .trapvect8(trapvect8), .offset9(offset9),
        .offset11(offset11), .ir11(ir11), .ir5(ir5), .ir4(ir4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready_low got=%b exp=0", in_ready); else passed++;
        reset = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else passed++;
        total++; if (count !== 2'd0) $display("FAIL rst_count got=%0d exp=0", count); else passed++;
        total++; if (out_inst !== 16'h0) $display("FAIL rst_out_inst got=%h exp=0000", out_inst); else passed++;
        total++; if (out_pc !== 16'h0) $display("FAIL rst_out_pc got=%h exp=0000", out_pc); else passed++;
        total++; if (dest !== 3'd0) $display("FAIL rst_dest got=%0d exp=0", dest); else passed++;
        total++; if (opcode !== 4'd0) $display("FAIL rst_opcode got=%0d exp=0", opcode); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready_high got=%b exp=1", in_ready); else passed++;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 16'h1042; in_pc = 16'h0000;
        step();
        in_inst = 16'h5FE3; in_pc = 16'h0002;
        total++; if (out_valid !== 1'b1) $display("FAIL s0_valid got=%b exp=1", out_valid); else passed++;
        total++; if (out_inst !== 16'h1042) $display("FAIL s0_inst got=%h exp=1042", out_inst); else passed++;
        total++; if (out_pc !== 16'h0000) $display("FAIL s0_pc got=%h exp=0000", out_pc); else passed++;
        total++; if (opcode !== 4'd1) $display("FAIL s0_opcode got=%0d exp=1", opcode); else passed++;
        total++; if (dest !== 3'd0) $display("FAIL s0_dest got=%0d exp=0", dest); else passed++;
        total++; if (sr1 !== 3'd1) $display("FAIL s0_sr1 got=%0d exp=1", sr1); else passed++;
        total++; if (sr2 !== 3'd2) $display("FAIL s0_sr2 got=%0d exp=2", sr2); else passed++;
        total++; if (ir5 !== 1'b0) $display("FAIL s0_ir5 got=%b exp=0", ir5); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL s0_in_ready got=%b exp=1", in_ready); else passed++;
        step();
        in_inst = 16'h4801; in_pc = 16'h0004;
        total++; if (out_inst !== 16'h5FE3) $display("FAIL s1_inst got=%h exp=5fe3", out_inst); else passed++;
        total++; if (out_pc !== 16'h0002) $display("FAIL s1_pc got=%h exp=0002", out_pc); else passed++;
        total++; if (opcode !== 4'd5) $display("FAIL s1_opcode got=%0d exp=5", opcode); else passed++;
        total++; if (dest !== 3'd7) $display("FAIL s1_dest got=%0d exp=7", dest); else passed++;
        total++; if (ir5 !== 1'b1) $display("FAIL s1_ir5 got=%b exp=1", ir5); else passed++;
        total++; if (imm5 !== 5'd3) $display("FAIL s1_imm5 got=%0d exp=3", imm5); else passed++;
        total++; if (count !== 2'd1) $display("FAIL s1_count got=%0d exp=1", count); else passed++;
        step();
        in_valid = 1'b0; in_inst = '0; in_pc = '0;
        total++; if (out_inst !== 16'h4801) $display("FAIL s2_inst got=%h exp=4801", out_inst); else passed++;
        total++; if (out_pc !== 16'h0004) $display("FAIL s2_pc got=%h exp=0004", out_pc); else passed++;
        total++; if (dest !== 3'd7) $display("FAIL s2_jsr_dest got=%0d exp=7", dest); else passed++;
        total++; if (ir11 !== 1'b1) $display("FAIL s2_ir11 got=%b exp=1", ir11); else passed++;
        total++; if (offset11 !== 11'h001) $display("FAIL s2_offset11 got=%h exp=001", offset11); else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL s3_empty got=%b exp=0", out_valid); else passed++;
        total++; if (out_inst !== 16'h0) $display("FAIL s3_inst_zero got=%h exp=0000", out_inst); else passed++;
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 16'h1111; in_pc = 16'h0010;
        step();
`ifdef IF_ID_SKID_EN
        total++; if (in_ready !== 1'b1) $display("FAIL st_rdy_after1 got=%b exp=1", in_ready); else passed++;
        in_inst = 16'h2222; in_pc = 16'h0012;
        step();
        in_inst = 16'h3333; in_pc = 16'h0014;
        total++; if (count !== 2'd2) $display("FAIL st_count2 got=%0d exp=2", count); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL st_rdy_full got=%b exp=0", in_ready); else passed++;
        step();
        total++; if (count !== 2'd2) $display("FAIL st_count_hold got=%0d exp=2", count); else passed++;
        total++; if (out_inst !== 16'h1111) $display("FAIL st_head_hold got=%h exp=1111", out_inst); else passed++;
        out_ready = 1'b1;
        step();
        total++; if (out_inst !== 16'h2222) $display("FAIL st_drain_b got=%h exp=2222", out_inst); else passed++;
        total++; if (out_pc !== 16'h0012) $display("FAIL st_drain_b_pc got=%h exp=0012", out_pc); else passed++;
        total++; if (count !== 2'd1) $display("FAIL st_count1 got=%0d exp=1", count); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL st_rdy_back got=%b exp=1", in_ready); else passed++;
`else
        in_inst = 16'h2222; in_pc = 16'h0012;
        total++; if (count !== 2'd1) $display("FAIL st_count1 got=%0d exp=1", count); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL st_rdy_full got=%b exp=0", in_ready); else passed++;
        step();
        total++; if (out_inst !== 16'h1111) $display("FAIL st_head_hold got=%h exp=1111", out_inst); else passed++;
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL st_rdy_comb got=%b exp=1", in_ready); else passed++;
        step();
        in_inst = 16'h3333; in_pc = 16'h0014;
        total++; if (out_inst !== 16'h2222) $display("FAIL st_drain_b got=%h exp=2222", out_inst); else passed++;
        total++; if (out_pc !== 16'h0012) $display("FAIL st_drain_b_pc got=%h exp=0012", out_pc); else passed++;
`endif
        step();
        in_valid = 1'b0; in_inst = '0; in_pc = '0;
        total++; if (out_inst !== 16'h3333) $display("FAIL st_drain_c got=%h exp=3333", out_inst); else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL st_empty got=%b exp=0", out_valid); else passed++;
        total++; if (count !== 2'd0) $display("FAIL st_count0 got=%0d exp=0", count); else passed++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 16'h1AAA; in_pc = 16'h0020;
        step();
        in_inst = 16'h1BBB; in_pc = 16'h0022;
        step();
`ifdef IF_ID_SKID_EN
        total++; if (count !== 2'd2) $display("FAIL fl_pre_count got=%0d exp=2", count); else passed++;
`else
        total++; if (count !== 2'd1) $display("FAIL fl_pre_count got=%0d exp=1", count); else passed++;
`endif
        in_inst = 16'h1CCC; in_pc = 16'h0024; flush = 1'b1;
        step();
        total++; if (count !== 2'd0) $display("FAIL fl_count got=%0d exp=0", count); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL fl_valid got=%b exp=0", out_valid); else passed++;
        total++; if (out_inst !== 16'h0) $display("FAIL fl_inst got=%h exp=0000", out_inst); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL fl_rdy got=%b exp=1", in_ready); else passed++;
        in_inst = 16'h1DDD; in_pc = 16'h0026;
        step();
        flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
        total++; if (out_valid !== 1'b0) $display("FAIL fl_accept_dropped got=%b exp=0", out_valid); else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL fl_never_appears got=%b exp=0", out_valid); else passed++;
    endtask

    task automatic test_trap();
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 16'hF025; in_pc = 16'h0030;
        step();
        in_valid = 1'b0; in_inst = '0; in_pc = '0;
        total++; if (opcode !== 4'd15) $display("FAIL tr_opcode got=%0d exp=15", opcode); else passed++;
        total++; if (dest !== 3'd7) $display("FAIL tr_dest got=%0d exp=7", dest); else passed++;
        total++; if (trapvect8 !== 8'h25) $display("FAIL tr_vect got=%h exp=25", trapvect8); else passed++;
        total++; if (out_pc !== 16'h0030) $display("FAIL tr_pc got=%h exp=0030", out_pc); else passed++;
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 16'h1777; in_pc = 16'h0040;
        step();
        total++; if (count !== 2'd1) $display("FAIL rm_pre_count got=%0d exp=1", count); else passed++;
        out_ready = 1'b1; in_inst = 16'h1888; in_pc = 16'h0042; reset = 1'b0;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL rm_valid got=%b exp=0", out_valid); else passed++;
        total++; if (count !== 2'd0) $display("FAIL rm_count got=%0d exp=0", count); else passed++;
        total++; if (out_inst !== 16'h0) $display("FAIL rm_inst got=%h exp=0000", out_inst); else passed++;
        total++; if (out_pc !== 16'h0) $display("FAIL rm_pc got=%h exp=0000", out_pc); else passed++;
        total++; if (dest !== 3'd0) $display("FAIL rm_dest got=%0d exp=0", dest); else passed++;
        reset = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL rm_lost got=%b exp=0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL rm_rdy got=%b exp=1", in_ready); else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_trap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
